lsu_req_queue: RTL
==================

# lsu_req_queue

Request queue between the LSU issue logic and the store unit. It captures store/AMO requests (`lsu_ctrl_t`) from issue and presents them head-first on a `valid`/`pop` interface that the store unit drains through its `pop_st_o`. A request arriving while the queue is empty passes straight through in the same cycle. Otherwise requests are held in order until popped or flushed.

## Interface
- `DEPTH`, default 2: number of storage entries; must be a power of two and at least 2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all entries and any pushes this cycle.
- `valid_i` in 1: issue presents a new request.
- `lsu_ctrl_i` in `lsu_ctrl_t`: request payload.
- `ready_o` out 1: queue accepts a push this cycle.
- `valid_o` out 1: head request available to the store unit.
- `lsu_ctrl_o` out `lsu_ctrl_t`: head request payload.
- `pop_i` in 1: store unit consumes the head (driven from `pop_st_o`).
- `empty_o` out 1: no stored entries.
- `count_o` out `$clog2(DEPTH)+1`: number of stored entries.

## Operation
- Storage: `DEPTH` entries, read pointer and write pointer of `$clog2(DEPTH)` bits, and an occupancy counter of `$clog2(DEPTH)+1` bits.
- Pointers wrap modulo `DEPTH` naturally. Full when count == `DEPTH`; empty when count == 0.
- `ready_o = (count != DEPTH) | pop_i`. Push while full is permitted only when `pop_i` is high in the same cycle.
- Push: `valid_i & ready_o & !flush_i`. Payload is written at `wptr` and `wptr` increments.
- Pop: `pop_i & valid_o`. `rptr` increments. A pop while `valid_o` is low is ignored, and a bench assertion fires.
- Empty-bypass:
  - When count == 0, `valid_o = valid_i` and `lsu_ctrl_o = lsu_ctrl_i`.
  - If the same cycle pushes and pops, nothing is written and pointers and count stay unchanged.
  - If it pushes without a pop, the entry is stored normally.
- Non-empty: `valid_o = 1` and `lsu_ctrl_o = mem[rptr]`. A simultaneous push and pop writes at `wptr`, advances both pointers, and leaves count unchanged.
- Count update: +1 for push-only, −1 for pop-only, unchanged otherwise. It never exceeds `DEPTH` and never underflows.
- Flush:
  - Next cycle: count = 0 and both pointers = 0.
  - Same cycle: a push is blocked, `valid_o` stays as computed from the current state, and a pop this cycle has no lasting effect.
- Reset: count = 0 and pointers = 0. Memory contents are don't-care and need no reset.

## Timing
- Reset outputs: `valid_o = valid_i` (bypass), `ready_o = 1`, `empty_o = 1`, `count_o = 0`, `lsu_ctrl_o = lsu_ctrl_i`.
- Latency: 0 cycles when empty (combinational path `valid_i`→`valid_o`). Otherwise a pushed entry reaches the head after all older entries are popped, with a minimum of 1 cycle.
- `ready_o` depends combinationally on `pop_i`. Issue must not gate `valid_i` on `ready_o` combinationally in a loop back to `pop_i`.
- `empty_o` and `count_o` are registered-state derived and do not include the same-cycle push.
- Mid-operation reset clears all state asynchronously. Outputs take their reset values immediately.

## Structure
- `lsu_ctrl_t` and `TRANS_ID_BITS` come from `ariane_pkg`. No new package types are needed.
- Pointer/count width constants are local parameters.
- No sub-module. The memory is a flip-flop array inside the block.

## Test plan
- Empty bypass: `valid_i=1`, trans_id 3, `pop_i=1` in the same cycle → `valid_o=1` and `lsu_ctrl_o.trans_id=3` that cycle; next cycle count 0 and `valid_o` follows `valid_i=0`.
- Fill and order: push ids 1, 2 with `pop_i=0` → count 2, `ready_o=0` while `pop_i=0`; then pop twice → heads 1 then 2; count 0.
- Full with simultaneous push/pop: at count 2, push id 5 with `pop_i=1` → head advances, count stays 2, id 5 emerges after the remaining older entry.
- Wrap-around: 6 push/pop pairs at `DEPTH=2` with ids 0..5 → outputs strictly 0..5; no loss or duplication.
- Flush: at count 2, assert `flush_i` with `valid_i=1` → next cycle count 0, `empty_o=1`, the pushed id never appears.
- Reset mid-operation: at count 1, deassert `rst_ni` → `empty_o=1` and `count_o=0` immediately, `ready_o=1`; after release the old entry never appears.

Source files
------------

// File: rtl/ariane_pkg.sv
// Slice of the core-wide package: the LSU control record and the
// scoreboard transaction-id width that the store path carries along.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned VLEN          = 64;
  localparam int unsigned XLEN          = 64;

  // Functional unit that owns an instruction.
  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  // Operation subset relevant to the load/store path.
  typedef enum logic [7:0] {
    ADD,
    LD,
    LW,
    SD,
    SW,
    SH,
    SB,
    AMO_SWAPW,
    AMO_ADDW,
    AMO_SWAPD,
    AMO_ADDD
  } fu_op;

  // Request handed from LSU issue to the load and store units.
  typedef struct packed {
    logic                     valid;
    logic [VLEN-1:0]          vaddr;
    logic                     overflow;
    logic [XLEN-1:0]          data;
    logic [(XLEN/8)-1:0]      be;
    fu_t                      fu;
    fu_op                     operation;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } lsu_ctrl_t;

endpackage

// File: rtl/lsu_req_queue.sv
// Store/AMO request queue between LSU issue and the store unit.
// Requests arriving at an empty queue bypass storage combinationally;
// otherwise they are held in a small flip-flop FIFO until popped or flushed.
module lsu_req_queue
  import ariane_pkg::*;
#(
  // Must be a power of two and at least 2 so pointers wrap for free.
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  lsu_ctrl_t              lsu_ctrl_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output lsu_ctrl_t              lsu_ctrl_o,
  input  logic                   pop_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  lsu_ctrl_t          mem [DEPTH];
  logic [PTR_W-1:0]   rptr_reg, rptr_next;
  logic [PTR_W-1:0]   wptr_reg, wptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic write_en;
  logic pop_stored;

  // Head presentation, handshake and bookkeeping decisions for this cycle.
  always_comb begin
    empty      = (count_reg == '0);
    full       = (count_reg == FULL_CNT);
    // A full queue can still take a push when the head leaves this cycle.
    ready_o    = ~full | pop_i;
    // Empty queue forwards the incoming request straight to the store unit.
    valid_o    = empty ? valid_i : 1'b1;
    lsu_ctrl_o = empty ? lsu_ctrl_i : mem[rptr_reg];
    push       = valid_i & ready_o & ~flush_i;
    pop        = pop_i & valid_o;
    // A bypassed request consumed in the same cycle is never stored.
    write_en   = push & ~(empty & pop);
    // Only a pop of a stored entry moves the read side.
    pop_stored = pop & ~empty;
    empty_o    = empty;
    count_o    = count_reg;
  end

  // Next pointer and occupancy; flush discards everything at once.
  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    if (flush_i) begin
      rptr_next  = '0;
      wptr_next  = '0;
      count_next = '0;
    end else begin
      if (write_en)   wptr_next = wptr_reg + PTR_W'(1);
      if (pop_stored) rptr_next = rptr_reg + PTR_W'(1);
      unique case ({write_en, pop_stored})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy state, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  // Payload storage; contents are meaningless until written so no reset.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem[wptr_reg] <= lsu_ctrl_i;
    end
  end

endmodule
